// File: rtl/udp_tx_packetizer_if.sv
// UDP sink beat bus between the packetizer (master) and the UDP core (slave).
interface udp_tx_packetizer_if;
  logic        udp_sink_valid;
  logic        udp_sink_ready;
  logic        udp_sink_last;
  logic [15:0] udp_sink_dst_port;
  logic [15:0] udp_sink_length;
  logic [31:0] udp_sink_data;

  modport master (
    output udp_sink_valid,
    input  udp_sink_ready,
    output udp_sink_last,
    output udp_sink_dst_port,
    output udp_sink_length,
    output udp_sink_data
  );

  modport slave (
    input  udp_sink_valid,
    output udp_sink_ready,
    input  udp_sink_last,
    input  udp_sink_dst_port,
    input  udp_sink_length,
    input  udp_sink_data
  );
endinterface

// File: rtl/udp_tx_packetizer.sv
// Byte FIFO that frames buffered bytes into UDP payload packets of up to MAX_LEN beats.
// Optional idle auto-flush is compiled in when UDP_TX_TIMEOUT_EN is defined.
module udp_tx_packetizer #(
  parameter int          DEPTH_WIDTH = 10,
  parameter int          MAX_LEN     = 1024,
  parameter logic [15:0] DST_PORT    = 16'd6000,
  parameter logic [15:0] TIMEOUT     = 16'd50000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  input  logic                       flush,
  udp_tx_packetizer_if.master        udp_sink
);

  localparam int            CW        = DEPTH_WIDTH + 1;
  localparam int            DEPTH     = 1 << DEPTH_WIDTH;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_LEN_C = CW'(MAX_LEN);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic [1:0]             rst_pipe;
  logic                   rst_n;
  logic [7:0]             mem [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]          fifo_count, count_next;
  logic [CW-1:0]          len, len_next, len_clamp;
  logic [CW-1:0]          remaining, remaining_next;
  logic                   pend, pend_next;
  logic                   full, wr_en, rd_en;
  logic                   flush_req, timeout_hit, count_hit, trigger;

  // Reset asserts immediately but releases two clock edges later, aligned to clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_pipe <= 2'b00;
    else      rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  assign full       = (fifo_count == DEPTH_C);
  assign in_ready   = rst_n && !full;
  assign wr_en      = in_valid && in_ready;
  assign rd_en      = (state == SEND) && udp_sink.udp_sink_ready;
  assign count_next = fifo_count + CW'(wr_en) - CW'(rd_en);
  assign count_hit  = (count_next >= MAX_LEN_C);
  assign len_clamp  = count_hit ? MAX_LEN_C : count_next;
  assign flush_req  = flush || timeout_hit;

  // NOTE: the byte array has no reset; only pointers and count are cleared, so it can map to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

`ifdef UDP_TX_TIMEOUT_EN
  logic [15:0] idle_cnt;

  // Counts write-free cycles spent in FILL and saturates at TIMEOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         idle_cnt <= '0;
    else if (state != FILL || wr_en)    idle_cnt <= '0;
    else if (idle_cnt != TIMEOUT)       idle_cnt <= idle_cnt + 16'd1;
  end
  assign timeout_hit = (state == FILL) && !wr_en && (idle_cnt == TIMEOUT);
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      len        <= '0;
      remaining  <= '0;
      pend       <= 1'b0;
    end else begin
      state      <= state_next;
      fifo_count <= count_next;
      len        <= len_next;
      remaining  <= remaining_next;
      pend       <= pend_next;
      if (wr_en) wr_ptr <= wr_ptr + DEPTH_WIDTH'(1);
      if (rd_en) rd_ptr <= rd_ptr + DEPTH_WIDTH'(1);
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_next     = state;
    len_next       = len;
    remaining_next = remaining;
    pend_next      = pend;
    trigger        = 1'b0;

    case (state)
      IDLE, FILL: begin
        trigger = (flush_req && count_next != '0) || count_hit;
        if (trigger) begin
          state_next     = SEND;
          len_next       = len_clamp;
          remaining_next = len_clamp;
          pend_next      = 1'b0;
        end else begin
          state_next = (count_next != '0) ? FILL : IDLE;
        end
      end

      SEND: begin
        if (flush) pend_next = 1'b1;
        if (rd_en) begin
          remaining_next = remaining - ONE_C;
          if (remaining == ONE_C) begin
            // A pending flush with nothing new buffered has nothing to cover and is dropped.
            pend_next = 1'b0;
            if (count_hit || ((pend || flush) && count_next != '0)) begin
              trigger        = 1'b1;
              state_next     = SEND;
              len_next       = len_clamp;
              remaining_next = len_clamp;
            end else begin
              state_next = (count_next != '0) ? FILL : IDLE;
            end
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    udp_sink.udp_sink_valid  = 1'b0;
    udp_sink.udp_sink_last   = 1'b0;
    udp_sink.udp_sink_length = '0;
    udp_sink.udp_sink_data   = '0;
    if (state == SEND) begin
      udp_sink.udp_sink_valid  = 1'b1;
      udp_sink.udp_sink_last   = (remaining == ONE_C);
      udp_sink.udp_sink_length = 16'(len);
      udp_sink.udp_sink_data   = {24'd0, mem[rd_ptr]};
    end
  end

  assign udp_sink.udp_sink_dst_port = DST_PORT;

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Scoreboard bench for udp_tx_packetizer: instance A (MAX_LEN=16) and instance B (MAX_LEN=4).
module tb_udp_tx_packetizer;

  localparam logic [15:0] DST_A = 16'h1234;
  localparam logic [15:0] DST_B = 16'd6000;

  typedef struct {
    logic [7:0]  data;
    logic        last;
    logic [15:0] length;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst      [2];
  logic        in_valid [2];
  logic [7:0]  in_data  [2];
  logic        in_ready [2];
  logic        flush    [2];
  logic        ready    [2];
  logic        valid    [2];
  logic        last     [2];
  logic [15:0] length   [2];
  logic [15:0] dst      [2];
  logic [31:0] data     [2];
  logic [15:0] dst_exp  [2];

  beat_t exp_q0 [$];
  beat_t exp_q1 [$];
  int    checks = 0;
  int    errors = 0;

  udp_tx_packetizer_if sink_a ();
  udp_tx_packetizer_if sink_b ();

  udp_tx_packetizer #(
    .DEPTH_WIDTH(4), .MAX_LEN(16), .DST_PORT(DST_A), .TIMEOUT(16'd8)
  ) dut_a (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .flush(flush[0]), .udp_sink(sink_a)
  );

  udp_tx_packetizer #(
    .DEPTH_WIDTH(3), .MAX_LEN(4), .DST_PORT(DST_B), .TIMEOUT(16'd50000)
  ) dut_b (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .flush(flush[1]), .udp_sink(sink_b)
  );

  assign sink_a.udp_sink_ready = ready[0];
  assign sink_b.udp_sink_ready = ready[1];
  assign valid[0]  = sink_a.udp_sink_valid;
  assign valid[1]  = sink_b.udp_sink_valid;
  assign last[0]   = sink_a.udp_sink_last;
  assign last[1]   = sink_b.udp_sink_last;
  assign length[0] = sink_a.udp_sink_length;
  assign length[1] = sink_b.udp_sink_length;
  assign dst[0]    = sink_a.udp_sink_dst_port;
  assign dst[1]    = sink_b.udp_sink_dst_port;
  assign data[0]   = sink_a.udp_sink_data;
  assign data[1]   = sink_b.udp_sink_data;
  assign dst_exp[0] = DST_A;
  assign dst_exp[1] = DST_B;

  always #5 clk = ~clk;

  // Scoreboard: every accepted beat is popped from its instance queue and compared.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (valid[i] === 1'b1 && ready[i] === 1'b1) begin
        beat_t e;
        bit    have;
        have = (i == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
        checks++;
        if (!have) begin
          errors++;
          $display("FAIL beat[%0d]: unexpected beat data=%h len=%0d last=%b, expected none", i, data[i], length[i], last[i]);
        end else begin
          if (i == 0) e = exp_q0.pop_front();
          else        e = exp_q1.pop_front();
          if ({data[i], last[i], length[i], dst[i]} !== {24'd0, e.data, e.last, e.length, dst_exp[i]}) begin
            errors++;
            $display("FAIL beat[%0d]: got data=%h last=%b len=%0d port=%h, expected data=%h last=%b len=%0d port=%h",
                     i, data[i], last[i], length[i], dst[i], e.data, e.last, e.length, dst_exp[i]);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int qsize(input int sel);
    return (sel == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic push_pkt(input int sel, input logic [7:0] first, input int n);
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b.data   = first + 8'(k);
      b.last   = (k == n - 1);
      b.length = 16'(n);
      if (sel == 0) exp_q0.push_back(b);
      else          exp_q1.push_back(b);
    end
  endtask

  task automatic write_bytes(input int sel, input logic [7:0] first, input int n);
    for (int k = 0; k < n; k++) begin
      in_valid[sel] = 1'b1;
      in_data[sel]  = first + 8'(k);
      step();
    end
    in_valid[sel] = 1'b0;
  endtask

  task automatic pulse_flush(input int sel);
    flush[sel] = 1'b1;
    step();
    flush[sel] = 1'b0;
  endtask

  task automatic wait_drain(input int sel, input int budget, output bit drained);
    int n = 0;
    while (n < budget && (qsize(sel) != 0 || valid[sel] !== 1'b0)) begin
      @(negedge clk);
      n++;
    end
    drained = (qsize(sel) == 0) && (valid[sel] === 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0; in_valid[i] = 1'b0; in_data[i] = 8'h00; flush[i] = 1'b0; ready[i] = 1'b0;
    end
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (in_ready[i] !== 1'b0) begin
        errors++; $display("FAIL reset_in_ready_held[%0d]: got %b, expected 0", i, in_ready[i]);
      end
      checks++;
      if ({valid[i], last[i], length[i], data[i]} !== 50'd0) begin
        errors++; $display("FAIL reset_outputs[%0d]: got valid=%b last=%b len=%0d data=%h, expected all 0", i, valid[i], last[i], length[i], data[i]);
      end
    end
    rst[0] = 1'b1; rst[1] = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (in_ready[i] !== 1'b1) begin
        errors++; $display("FAIL reset_in_ready_released[%0d]: got %b, expected 1", i, in_ready[i]);
      end
      checks++;
      if (valid[i] !== 1'b0) begin
        errors++; $display("FAIL reset_idle_valid[%0d]: got %b, expected 0", i, valid[i]);
      end
    end
  endtask

  task automatic test_basic();
    bit ok;
    ready[0] = 1'b1;
    push_pkt(0, 8'h01, 5);
    write_bytes(0, 8'h01, 5);
    flush[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (valid[0] !== 1'b0) begin
      errors++; $display("FAIL basic_valid_on_flush: got %b, expected 0", valid[0]);
    end
    step();
    flush[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (valid[0] !== 1'b1) begin
      errors++; $display("FAIL basic_valid_after_flush: got %b, expected 1", valid[0]);
    end
    wait_drain(0, 40, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL basic_drain: %0d beats outstanding, expected 0", qsize(0));
    end
  endtask

  task automatic test_max_len();
    bit ok;
    ready[1] = 1'b1;
    push_pkt(1, 8'h10, 4);
    push_pkt(1, 8'h14, 4);
    write_bytes(1, 8'h10, 10);
    wait_drain(1, 40, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL maxlen_drain: %0d beats outstanding, expected 0", qsize(1));
    end
    step();
    checks++;
    if (dut_b.fifo_count !== 4'd2 || valid[1] !== 1'b0) begin
      errors++; $display("FAIL maxlen_leftover: got count=%0d valid=%b, expected count=2 valid=0", dut_b.fifo_count, valid[1]);
    end
    push_pkt(1, 8'h18, 2);
    pulse_flush(1);
    wait_drain(1, 40, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL maxlen_flush_drain: %0d beats outstanding, expected 0", qsize(1));
    end
  endtask

  task automatic test_stall();
    bit ok;
    ready[0] = 1'b0;
    push_pkt(0, 8'h21, 4);
    write_bytes(0, 8'h21, 4);
    flush[0] = 1'b1;
    step();
    flush[0] = 1'b0;
    ready[0] = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      ready[0] = 1'b0;
      @(negedge clk);
      checks++;
      if ({valid[0], data[0], last[0], length[0]} !== {1'b1, 32'h22, 1'b0, 16'd4}) begin
        errors++; $display("FAIL stall_hold[%0d]: got valid=%b data=%h last=%b len=%0d, expected valid=1 data=22 last=0 len=4",
                           k, valid[0], data[0], last[0], length[0]);
      end
      step();
    end
    ready[0] = 1'b1;
    wait_drain(0, 40, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL stall_drain: %0d beats outstanding, expected 0", qsize(0));
    end
  endtask

  task automatic test_flush_empty();
    int seen = 0;
    step();
    flush[0] = 1'b1;
    step();
    flush[0] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (valid[0] !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL flush_empty: got %0d valid cycles, expected 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit found = 1'b0;
    ready[0] = 1'b1;
    push_pkt(0, 8'h31, 6);
    push_pkt(0, 8'h41, 3);
    write_bytes(0, 8'h31, 6);
    pulse_flush(0);
    flush[0] = 1'b1;
    write_bytes(0, 8'h41, 1);
    flush[0] = 1'b0;
    write_bytes(0, 8'h42, 2);
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (valid[0] === 1'b1 && last[0] === 1'b1 && ready[0] === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL b2b_first_last: last beat not seen within 20 cycles, expected it");
    end
    @(negedge clk);
    checks++;
    if ({valid[0], length[0], data[0]} !== {1'b1, 16'd3, 32'h41}) begin
      errors++; $display("FAIL b2b_second_start: got valid=%b len=%0d data=%h, expected valid=1 len=3 data=41", valid[0], length[0], data[0]);
    end
    wait_drain(0, 40, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b_drain: %0d beats outstanding, expected 0", qsize(0));
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    ready[0] = 1'b1;
    push_pkt(0, 8'h51, 5);
    write_bytes(0, 8'h51, 5);
    pulse_flush(0);
    repeat (2) step();
    rst[0] = 1'b0;
    #1;
    exp_q0.delete();
    checks++;
    if ({valid[0], last[0], dut_a.fifo_count, in_ready[0]} !== 8'd0) begin
      errors++; $display("FAIL reset_mid: got valid=%b last=%b count=%0d in_ready=%b, expected all 0",
                         valid[0], last[0], dut_a.fifo_count, in_ready[0]);
    end
    repeat (2) step();
    rst[0] = 1'b1;
    repeat (3) step();
    push_pkt(0, 8'h61, 1);
    write_bytes(0, 8'h61, 1);
    pulse_flush(0);
    wait_drain(0, 40, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL reset_mid_drain: %0d beats outstanding, expected 0", qsize(0));
    end
  endtask

`ifdef UDP_TX_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int k = 0;
    ready[0] = 1'b1;
    push_pkt(0, 8'h71, 3);
    write_bytes(0, 8'h71, 3);
    while (valid[0] !== 1'b1 && k < 30) begin
      step();
      k++;
    end
    checks++;
    if (k != 9) begin
      errors++; $display("FAIL timeout_start: got valid after %0d cycles, expected 9", k);
    end
    wait_drain(0, 40, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL timeout_drain: %0d beats outstanding, expected 0", qsize(0));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_max_len();
    test_stall();
    test_flush_empty();
    test_back_to_back();
    test_reset_mid();
`ifdef UDP_TX_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) step();
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++; $display("FAIL final_queues: got %0d/%0d beats outstanding, expected 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
